// File: rtl/open_list_cmd_adapter.sv
// Command adapter in front of the systolic open-list min-queue: stages pushes in a FIFO,
// applies the post-command settle guard and returns popped minima. Optional: OPEN_LIST_BYPASS_EN.
module open_list_cmd_adapter #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned QUEUE_SIZE    = 2048,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 1,
  localparam int unsigned CNT_W        = $clog2(2 * QUEUE_SIZE + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  s_push_valid,
  output logic                  s_push_ready,
  input  logic [DATA_WIDTH-1:0] s_push_f,
  input  logic                  s_pop_valid,
  output logic                  s_pop_ready,
  output logic                  m_pop_valid,
  input  logic                  m_pop_ready,
  output logic [DATA_WIDTH-1:0] m_pop_f,
  output logic                  q_wrt,
  output logic                  q_read,
  output logic [DATA_WIDTH-1:0] q_node_f,
  input  logic                  q_full,
  input  logic                  q_empty,
  input  logic [DATA_WIDTH-1:0] q_head_f,
  output logic [CNT_W-1:0]      o_count
);

  localparam int unsigned CAPACITY = 2 * QUEUE_SIZE;
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W    = PTR_W + 1;
  localparam int unsigned GUARD_W  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StHold
  } state_e;

  state_e                r_state;
  state_e                w_state_next;

  logic [DATA_WIDTH-1:0] r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_fifo_level;
  logic [GUARD_W-1:0]    r_guard;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_result;

  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic [DATA_WIDTH-1:0] w_fifo_head;
  logic                  w_push_acc;
  logic                  w_pop_acc;
  logic                  w_settled;
  logic                  w_pop_ok;
  logic                  w_below_cap;

  logic                  w_wrt;
  logic                  w_rd;
  logic                  w_fifo_pop;
  logic                  w_issue;
  logic                  w_cnt_inc;
  logic                  w_cnt_dec;
  logic [DATA_WIDTH-1:0] w_capture_f;

  // ---------------------------------------------------------------------------
  // Push staging FIFO
  // ---------------------------------------------------------------------------
  assign w_fifo_empty = (r_fifo_level == '0);
  assign w_fifo_full  = (r_fifo_level == LVL_W'(FIFO_DEPTH));
  assign w_fifo_head  = r_fifo_mem[r_rd_ptr];
  assign w_push_acc   = s_push_valid && !w_fifo_full;
  assign s_push_ready = !w_fifo_full;

  // Storage needs no reset: q_node_f is gated by q_wrt and the level tracks validity.
  always_ff @(posedge CLK) begin
    if (w_push_acc) begin
      r_fifo_mem[r_wr_ptr] <= s_push_f;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_level <= '0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_fifo_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_acc, w_fifo_pop})
        2'b10:   r_fifo_level <= r_fifo_level + LVL_W'(1);
        2'b01:   r_fifo_level <= r_fifo_level - LVL_W'(1);
        default: r_fifo_level <= r_fifo_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Settle guard and occupancy
  // ---------------------------------------------------------------------------
  assign w_settled   = (r_guard == '0);
  assign w_below_cap = (r_count < CNT_W'(CAPACITY));
  assign w_pop_acc   = s_pop_valid && (r_state == StIdle);
  assign w_pop_ok    = (r_state == StWait) && w_settled;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_guard <= '0;
    end else if (w_wrt || w_rd) begin
      r_guard <= GUARD_W'(SETTLE_CYCLES);
    end else if (!w_settled) begin
      r_guard <= r_guard - GUARD_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count <= '0;
    end else begin
      case ({w_cnt_inc, w_cnt_dec})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_result <= '0;
    end else if (w_issue) begin
      r_result <= w_capture_f;
    end
  end

  assign m_pop_f = r_result;
  assign o_count = r_count;

  // ---------------------------------------------------------------------------
  // Pop FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Pop FSM: next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_pop_acc) begin
          w_state_next = StWait;
        end
      end
      StWait: begin
        if (w_issue) begin
          w_state_next = StHold;
        end
      end
      StHold: begin
        if (m_pop_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Pop FSM: outputs and single-command arbitration (pop side wins over pushes)
  always_comb begin
    w_wrt       = 1'b0;
    w_rd        = 1'b0;
    w_fifo_pop  = 1'b0;
    w_issue     = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cnt_dec   = 1'b0;
    w_capture_f = q_head_f;

    s_pop_ready = (r_state == StIdle);
    m_pop_valid = (r_state == StHold);

    if (w_pop_ok && !q_empty && w_fifo_empty) begin
      w_rd      = 1'b1;
      w_issue   = 1'b1;
      w_cnt_dec = 1'b1;
`ifdef OPEN_LIST_BYPASS_EN
    end else if (w_pop_ok && !w_fifo_empty) begin
      w_fifo_pop = 1'b1;
      w_issue    = 1'b1;
      if (q_empty || (w_fifo_head < q_head_f)) begin
        // Staged value is the true minimum: hand it back without touching the queue.
        w_capture_f = w_fifo_head;
      end else begin
        // Replace keeps occupancy constant, so it is legal even when the queue is full.
        w_wrt = 1'b1;
        w_rd  = 1'b1;
      end
`endif
    end else if (!w_fifo_empty && !q_full && w_below_cap) begin
      w_wrt      = 1'b1;
      w_fifo_pop = 1'b1;
      w_cnt_inc  = 1'b1;
    end

    q_wrt    = w_wrt;
    q_read   = w_rd;
    q_node_f = w_wrt ? w_fifo_head : '0;
  end

endmodule

// File: tb/tb_open_list_cmd_adapter.sv
// Directed self-checking bench for open_list_cmd_adapter with a behavioural min-queue model.
// Build with +define+OPEN_LIST_BYPASS_EN to also exercise the bypass/replace path.
module tb_open_list_cmd_adapter;

  localparam int unsigned DW = 16;
  localparam int unsigned QS = 4;
  localparam int unsigned FD = 4;
  localparam int unsigned SC = 1;
  localparam int unsigned CW = $clog2(2 * QS + 1);

  logic          CLK;
  logic          RST;
  logic          s_push_valid;
  logic          s_push_ready;
  logic [DW-1:0] s_push_f;
  logic          s_pop_valid;
  logic          s_pop_ready;
  logic          m_pop_valid;
  logic          m_pop_ready;
  logic [DW-1:0] m_pop_f;
  logic          q_wrt;
  logic          q_read;
  logic [DW-1:0] q_node_f;
  logic          q_full;
  logic          q_empty;
  logic [DW-1:0] q_head_f;
  logic [CW-1:0] o_count;

  int n_checks = 0;
  int n_errors = 0;

  open_list_cmd_adapter #(
    .DATA_WIDTH   (DW),
    .QUEUE_SIZE   (QS),
    .FIFO_DEPTH   (FD),
    .SETTLE_CYCLES(SC)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .s_push_valid(s_push_valid),
    .s_push_ready(s_push_ready),
    .s_push_f    (s_push_f),
    .s_pop_valid (s_pop_valid),
    .s_pop_ready (s_pop_ready),
    .m_pop_valid (m_pop_valid),
    .m_pop_ready (m_pop_ready),
    .m_pop_f     (m_pop_f),
    .q_wrt       (q_wrt),
    .q_read      (q_read),
    .q_node_f    (q_node_f),
    .q_full      (q_full),
    .q_empty     (q_empty),
    .q_head_f    (q_head_f),
    .o_count     (o_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural min-queue: sorted ascending, head is element 0.
  int model_q[$];

  function automatic void model_insert(input int v);
    int pos;
    pos = model_q.size();
    for (int i = 0; i < model_q.size(); i++) begin
      if (v < model_q[i]) begin
        pos = i;
        break;
      end
    end
    model_q.insert(pos, v);
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      model_q.delete();
      q_empty  <= 1'b1;
      q_full   <= 1'b0;
      q_head_f <= '0;
    end else begin
      if (q_read && model_q.size() > 0) model_q.delete(0);
      if (q_wrt) model_insert(int'(q_node_f));
      q_empty  <= (model_q.size() == 0);
      q_full   <= (model_q.size() >= int'(2 * QS));
      q_head_f <= (model_q.size() > 0) ? DW'(model_q[0]) : '0;
    end
  end

  // Protocol monitor sampled mid-cycle.
  int   n_wrt = 0, n_read = 0, n_both = 0;
  int   n_settle_viol = 0, n_full_viol = 0, n_excl_viol = 0;
  logic prev_cmd;

  always @(negedge CLK) begin
    if (RST) begin
      prev_cmd <= 1'b0;
    end else begin
      prev_cmd <= q_wrt || q_read;
      if (q_wrt) n_wrt <= n_wrt + 1;
      if (q_read) n_read <= n_read + 1;
      if (q_wrt && q_read) n_both <= n_both + 1;
      if (q_read && prev_cmd === 1'b1) n_settle_viol <= n_settle_viol + 1;
`ifdef OPEN_LIST_BYPASS_EN
      if (q_wrt && !q_read && q_full) n_full_viol <= n_full_viol + 1;
`else
      if (q_wrt && q_full) n_full_viol <= n_full_viol + 1;
      if (q_wrt && q_read) n_excl_viol <= n_excl_viol + 1;
`endif
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic push_one(input logic [DW-1:0] v, output bit ok);
    ok           = 1'b0;
    s_push_valid = 1'b1;
    s_push_f     = v;
    for (int i = 0; i < 50; i++) begin
      if (s_push_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    s_push_valid = 1'b0;
  endtask

  task automatic pop_req(output logic [DW-1:0] f, output bit ok);
    bit accepted;
    accepted    = 1'b0;
    ok          = 1'b0;
    f           = '0;
    s_pop_valid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      if (s_pop_ready) accepted = 1'b1;
      tick();
    end
    s_pop_valid = 1'b0;
    if (accepted) begin
      for (int i = 0; i < 50; i++) begin
        if (m_pop_valid) begin
          ok = 1'b1;
          f  = m_pop_f;
          break;
        end
        tick();
      end
    end
  endtask

  task automatic consume();
    m_pop_ready = 1'b1;
    tick();
    m_pop_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    n_checks++; if (s_push_ready !== 1'b1) begin n_errors++; $display("FAIL reset_push_ready: got %b expected 1", s_push_ready); end
    n_checks++; if (s_pop_ready !== 1'b1) begin n_errors++; $display("FAIL reset_pop_ready: got %b expected 1", s_pop_ready); end
    n_checks++; if (m_pop_valid !== 1'b0) begin n_errors++; $display("FAIL reset_m_valid: got %b expected 0", m_pop_valid); end
    n_checks++; if (m_pop_f !== '0) begin n_errors++; $display("FAIL reset_m_f: got %0d expected 0", m_pop_f); end
    n_checks++; if (q_wrt !== 1'b0 || q_read !== 1'b0) begin n_errors++; $display("FAIL reset_cmds: got wrt=%b read=%b expected 0 0", q_wrt, q_read); end
    n_checks++; if (q_node_f !== '0) begin n_errors++; $display("FAIL reset_node_f: got %0d expected 0", q_node_f); end
    n_checks++; if (o_count !== '0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", o_count); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_push_pop_order();
    bit            ok;
    logic [DW-1:0] f;
    logic [DW-1:0] exp_f [3];
    logic [CW-1:0] exp_c [3];
    exp_f[0] = 16'd3; exp_f[1] = 16'd7; exp_f[2] = 16'd9;
    exp_c[0] = CW'(2); exp_c[1] = CW'(1); exp_c[2] = CW'(0);
    push_one(16'd7, ok);
    push_one(16'd3, ok);
    push_one(16'd9, ok);
    tick();
    tick();
    n_checks++; if (o_count !== CW'(3)) begin n_errors++; $display("FAIL order_count_after_push: got %0d expected 3", o_count); end
    for (int i = 0; i < 3; i++) begin
      pop_req(f, ok);
      n_checks++; if (!ok || f !== exp_f[i]) begin n_errors++; $display("FAIL order_pop%0d: got %0d (ok=%b) expected %0d", i, f, ok, exp_f[i]); end
      n_checks++; if (o_count !== exp_c[i]) begin n_errors++; $display("FAIL order_count%0d: got %0d expected %0d", i, o_count, exp_c[i]); end
      consume();
    end
  endtask

  task automatic test_wait_empty();
    bit            ok;
    bit            early;
    bit            blocked;
    logic [DW-1:0] f;
    early   = 1'b0;
    blocked = 1'b1;
    s_pop_valid = 1'b1;
    tick();
    s_pop_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m_pop_valid !== 1'b0) early = 1'b1;
      if (s_pop_ready !== 1'b0) blocked = 1'b0;
      tick();
    end
    n_checks++; if (early) begin n_errors++; $display("FAIL wait_no_early_valid: got m_pop_valid=1 expected 0"); end
    n_checks++; if (!blocked) begin n_errors++; $display("FAIL wait_pop_ready_low: got s_pop_ready=1 expected 0"); end
    push_one(16'd5, ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_pop_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    f = m_pop_f;
    n_checks++; if (!ok || f !== 16'd5) begin n_errors++; $display("FAIL wait_result: got %0d (ok=%b) expected 5", f, ok); end
    n_checks++; if (o_count !== '0) begin n_errors++; $display("FAIL wait_count: got %0d expected 0", o_count); end
    n_checks++; if (n_settle_viol !== 0) begin n_errors++; $display("FAIL settle_guard: got %0d reads right after a command expected 0", n_settle_viol); end
    consume();
  endtask

  task automatic test_hold();
    bit            ok;
    bit            held;
    bit            blocked;
    logic [DW-1:0] f;
    int            reads0;
    held    = 1'b1;
    blocked = 1'b1;
    push_one(16'd20, ok);
    tick();
    tick();
    reads0 = n_read;
    pop_req(f, ok);
    n_checks++; if (!ok || f !== 16'd20) begin n_errors++; $display("FAIL hold_result: got %0d (ok=%b) expected 20", f, ok); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (m_pop_valid !== 1'b1 || m_pop_f !== 16'd20) held = 1'b0;
      if (s_pop_ready !== 1'b0) blocked = 1'b0;
    end
    n_checks++; if (!held) begin n_errors++; $display("FAIL hold_stable: got valid=%b f=%0d expected 1 20", m_pop_valid, m_pop_f); end
    n_checks++; if (!blocked) begin n_errors++; $display("FAIL hold_pop_ready: got 1 during hold expected 0"); end
    consume();
    n_checks++; if (m_pop_valid !== 1'b0 || s_pop_ready !== 1'b1) begin n_errors++; $display("FAIL hold_release: got valid=%b ready=%b expected 0 1", m_pop_valid, s_pop_ready); end
    tick();
    tick();
    n_checks++; if (n_read - reads0 !== 1) begin n_errors++; $display("FAIL hold_single_read: got %0d reads expected 1", n_read - reads0); end
    n_checks++; if (o_count !== '0) begin n_errors++; $display("FAIL hold_count: got %0d expected 0", o_count); end
  endtask

  task automatic test_full();
    bit ok;
    int acc;
    int wrt0;
    acc  = 0;
    wrt0 = n_wrt;
    for (int i = 0; i < int'(2 * QS); i++) push_one(DW'(40 + i), ok);
    tick();
    tick();
    n_checks++; if (o_count !== CW'(2 * QS)) begin n_errors++; $display("FAIL full_count: got %0d expected %0d", o_count, 2 * QS); end
    s_push_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_push_f = DW'(50 + i);
      if (s_push_ready) acc++;
      tick();
    end
    s_push_valid = 1'b0;
    n_checks++; if (acc !== int'(FD)) begin n_errors++; $display("FAIL full_accepts: got %0d expected %0d", acc, FD); end
    n_checks++; if (s_push_ready !== 1'b0) begin n_errors++; $display("FAIL full_push_ready: got %b expected 0", s_push_ready); end
    n_checks++; if (n_wrt - wrt0 !== int'(2 * QS)) begin n_errors++; $display("FAIL full_writes: got %0d expected %0d", n_wrt - wrt0, 2 * QS); end
    n_checks++; if (n_full_viol !== 0) begin n_errors++; $display("FAIL full_no_wrt: got %0d writes while full expected 0", n_full_viol); end
    n_checks++; if (o_count !== CW'(2 * QS)) begin n_errors++; $display("FAIL full_count_hold: got %0d expected %0d", o_count, 2 * QS); end
  endtask

  task automatic test_reset_mid_wait();
    bit            ok;
    logic [DW-1:0] f;
    apply_reset();
    for (int i = 0; i < int'(2 * QS); i++) push_one(DW'(40 + i), ok);
    push_one(16'd60, ok);
    push_one(16'd61, ok);
    tick();
    s_pop_valid = 1'b1;
    tick();
    s_pop_valid = 1'b0;
    tick();
    tick();
    n_checks++; if (s_pop_ready !== 1'b0) begin n_errors++; $display("FAIL rst_pre_pending: got %b expected 0", s_pop_ready); end
    #2;
    RST = 1'b1;
    #1;
    n_checks++; if (s_push_ready !== 1'b1 || s_pop_ready !== 1'b1) begin n_errors++; $display("FAIL rst_mid_ready: got push=%b pop=%b expected 1 1", s_push_ready, s_pop_ready); end
    n_checks++; if (m_pop_valid !== 1'b0 || m_pop_f !== '0) begin n_errors++; $display("FAIL rst_mid_result: got valid=%b f=%0d expected 0 0", m_pop_valid, m_pop_f); end
    n_checks++; if (q_wrt !== 1'b0 || q_read !== 1'b0 || q_node_f !== '0) begin n_errors++; $display("FAIL rst_mid_cmds: got wrt=%b read=%b node=%0d expected 0 0 0", q_wrt, q_read, q_node_f); end
    n_checks++; if (o_count !== '0) begin n_errors++; $display("FAIL rst_mid_count: got %0d expected 0", o_count); end
    tick();
    RST = 1'b0;
    tick();
    push_one(16'd1, ok);
    tick();
    tick();
    pop_req(f, ok);
    n_checks++; if (!ok || f !== 16'd1) begin n_errors++; $display("FAIL rst_after_pop: got %0d (ok=%b) expected 1", f, ok); end
    n_checks++; if (o_count !== '0) begin n_errors++; $display("FAIL rst_after_count: got %0d expected 0", o_count); end
    consume();
    tick();
  endtask

`ifdef OPEN_LIST_BYPASS_EN
  task automatic test_bypass();
    bit            ok;
    int            cmds0;
    int            both0;
    push_one(16'd10, ok);
    tick();
    tick();
    cmds0 = n_wrt + n_read;
    s_push_valid = 1'b1;
    s_push_f     = 16'd2;
    s_pop_valid  = 1'b1;
    tick();
    s_push_valid = 1'b0;
    s_pop_valid  = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_pop_valid) begin ok = 1'b1; break; end
      tick();
    end
    n_checks++; if (!ok || m_pop_f !== 16'd2) begin n_errors++; $display("FAIL bypass_direct: got %0d (ok=%b) expected 2", m_pop_f, ok); end
    n_checks++; if (n_wrt + n_read - cmds0 !== 0) begin n_errors++; $display("FAIL bypass_no_cmd: got %0d commands expected 0", n_wrt + n_read - cmds0); end
    n_checks++; if (o_count !== CW'(1)) begin n_errors++; $display("FAIL bypass_count: got %0d expected 1", o_count); end
    consume();
    tick();
    tick();
    both0 = n_both;
    s_push_valid = 1'b1;
    s_push_f     = 16'd12;
    s_pop_valid  = 1'b1;
    tick();
    s_push_valid = 1'b0;
    s_pop_valid  = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_pop_valid) begin ok = 1'b1; break; end
      tick();
    end
    n_checks++; if (!ok || m_pop_f !== 16'd10) begin n_errors++; $display("FAIL replace_result: got %0d (ok=%b) expected 10", m_pop_f, ok); end
    n_checks++; if (n_both - both0 !== 1) begin n_errors++; $display("FAIL replace_cmd: got %0d replaces expected 1", n_both - both0); end
    n_checks++; if (o_count !== CW'(1)) begin n_errors++; $display("FAIL replace_count: got %0d expected 1", o_count); end
    consume();
    tick();
  endtask
`endif

  initial begin
    RST          = 1'b1;
    s_push_valid = 1'b0;
    s_push_f     = '0;
    s_pop_valid  = 1'b0;
    m_pop_ready  = 1'b0;
    test_reset();
    test_push_pop_order();
    test_wait_empty();
    test_hold();
    test_full();
    test_reset_mid_wait();
`ifdef OPEN_LIST_BYPASS_EN
    test_bypass();
`endif
    n_checks++; if (n_settle_viol !== 0) begin n_errors++; $display("FAIL final_settle: got %0d violations expected 0", n_settle_viol); end
    n_checks++; if (n_full_viol !== 0) begin n_errors++; $display("FAIL final_full: got %0d violations expected 0", n_full_viol); end
    n_checks++; if (n_excl_viol !== 0) begin n_errors++; $display("FAIL final_exclusive: got %0d violations expected 0", n_excl_viol); end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/open_list_cmd_adapter.md
# open_list_cmd_adapter

Front-end stage that sits directly upstream of the systolic open-list min-queue. It converts a valid/ready push stream from the node expander and a valid/ready pop request/response pair into the queue's raw write/read/replace commands. It stages pushes in a small FIFO and enforces the queue's post-command settle time before sampling the head. It also tracks occupancy and returns the popped minimum on a held output register.

## Interface
Parameters:
- DATA_WIDTH, 16, node f-value width
- QUEUE_SIZE, 2048, downstream queue positions; capacity is 2*QUEUE_SIZE
- FIFO_DEPTH, 4, push staging FIFO entries (power of two, >=2)
- SETTLE_CYCLES, 1, idle cycles required after any queue command before the queue head may be sampled

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous, active-high reset
- s_push_valid  in  1  push offered
- s_push_ready  out  1  FIFO not full
- s_push_f  in  DATA_WIDTH  pushed f-value
- s_pop_valid  in  1  pop request
- s_pop_ready  out  1  no pop pending and result register empty
- m_pop_valid  out  1  result valid
- m_pop_ready  in  1  result consumed
- m_pop_f  out  DATA_WIDTH  popped minimum
- q_wrt  out  1  to queue i_wrt (combinational from registered state)
- q_read  out  1  to queue i_read
- q_node_f  out  DATA_WIDTH  to queue i_node_f (FIFO head)
- q_full  in  1  from queue o_full
- q_empty  in  1  from queue o_empty
- q_head_f  in  DATA_WIDTH  from queue o_node_f
- o_count  out  $clog2(2*QUEUE_SIZE+1)  adapter-tracked queue occupancy

## Operation
- Push handshake completes on s_push_valid && s_push_ready. The value enters the FIFO tail.
- Pop handshake completes on s_pop_valid && s_pop_ready. It sets a pending flag.
- FSM states:
  - IDLE: no pop pending.
  - WAIT: pop pending, waiting for the settle guard, data, or queue.
  - HOLD: m_pop_valid high.
- Transitions:
  - IDLE->WAIT on pop accept.
  - WAIT->HOLD on pop issue or bypass.
  - HOLD->IDLE on m_pop_ready.
- Settle guard counter: loaded with SETTLE_CYCLES on any cycle where q_wrt or q_read is high. Decrements to 0 otherwise. The head is "settled" when the guard is 0.
- The block issues at most one command per cycle, with this priority:
  1. Pop: in WAIT, guard 0, !q_empty, FIFO empty. Drive q_read=1, capture q_head_f into m_pop_f, go to HOLD, decrement count.
  2. Push: FIFO non-empty, !q_full, count<2*QUEUE_SIZE. Drive q_wrt=1 and q_node_f=FIFO head, pop the FIFO, increment count. Pushes may issue every cycle.
- Pop in WAIT with queue empty and FIFO empty: the block stalls in WAIT indefinitely. It has no timeout.
- q_wrt and q_read are never both high in base build.
- A push to the queue while q_full is never issued. The FIFO backs up and s_push_ready falls when the FIFO is full.
- Count arithmetic is unsigned and saturation-free. The invariants are 0<=o_count<=2*QUEUE_SIZE.

## Timing
- Reset (async, while RST=1): FIFO empty, s_push_ready=1, s_pop_ready=1, m_pop_valid=0, m_pop_f=0, q_wrt=0, q_read=0, q_node_f=0, o_count=0, guard=0, state IDLE.
- RST asserted mid-operation discards pending pop, FIFO contents and the held result.
- Push latency: a value accepted at edge N drives q_wrt in cycle N+1 at the earliest.
- Pop latency: a request accepted at edge N issues q_read in cycle N+1 at the earliest. m_pop_valid rises at N+2.
- m_pop_f is stable while m_pop_valid && !m_pop_ready.
- A pop requires the guard to be 0. With SETTLE_CYCLES=1, a push in cycle t blocks a pop in cycle t+1; the pop may issue at t+2.
- Simultaneous push accept and FIFO drain in the same cycle keeps the FIFO level unchanged.

## Configuration
- OPEN_LIST_BYPASS_EN defined:
  - In WAIT with guard 0 and FIFO non-empty:
    - If q_empty, or FIFO head < q_head_f: return the FIFO head directly. Pop the FIFO and issue no queue command. Count is unchanged.
    - Else, if the FIFO head >= q_head_f and the queue is not empty: issue a replace (q_wrt=q_read=1, q_node_f=FIFO head) and capture q_head_f. Count is unchanged. Replace is allowed when q_full.
- OPEN_LIST_BYPASS_EN undefined: pops wait for the FIFO to drain fully, and q_wrt/q_read are mutually exclusive.

## Test plan
- Reset, push 7, 3, 9 back-to-back, then pop ×3 with m_pop_ready=1 -> outputs 3, 7, 9. o_count goes 3,2,1,0. No pop issues within SETTLE_CYCLES of a push.
- Pop request on an empty system, push 5 after 10 cycles -> the block stays in WAIT, then returns 5. m_pop_valid never rises early.
- Fill the queue to 2*QUEUE_SIZE (q_full=1), push 4 more -> s_push_ready=0 after FIFO_DEPTH accepts. No q_wrt while q_full.
- Hold m_pop_ready=0 for 5 cycles after a result -> m_pop_f held, s_pop_ready=0. Release -> single transfer.
- Bypass build: queue holds 10, FIFO holds 2, pop -> 2 with no queue command. Queue holds 10, FIFO holds 12, pop -> replace, output 10, o_count unchanged.
- Assert RST mid-WAIT with FIFO holding 2 entries -> all outputs return to reset values immediately. A later push 1 / pop returns 1.
